// File: rtl/div_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : div_arb_pkg
// Brief    : Shared types and defaults for the divider-sharing arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package div_arb_pkg;

   localparam int DATA_WIDTH_DEF  = 10;
   localparam int CALC_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] quotient;
      logic [DATA_WIDTH_DEF-1:0] remainder;
      logic                      div_by_0;
   } div_result_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or above ptr.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic [ID_WIDTH-1:0] i_ptr,
   output logic [NUM_REQ-1:0]  o_grant,
   output logic [ID_WIDTH-1:0] o_grant_idx,
   output logic                o_any_req
);

   int w_idx;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any_req   = 1'b0;
      w_idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_any_req && i_req[w_idx]) begin
            o_any_req      = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = ID_WIDTH'(w_idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/div_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : div_share_arbiter
// Brief    : Round-robin sharing of one multicycle combinational divider.
//            Optional macro DIV_ZERO_BYPASS_EN: zero divisors skip CALC.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module div_share_arbiter
   import div_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int CALC_CYCLES = CALC_CYCLES_DEF,
   parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_quotient,
   output logic [DATA_WIDTH-1:0]         rsp_remainder,
   output logic                          rsp_div_by_0,
   output logic                          busy
);

   localparam int                   CNT_W      = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     c_cnt_init = CNT_W'(CALC_CYCLES - 1);
   localparam logic [ID_WIDTH-1:0]  c_last_id  = ID_WIDTH'(NUM_REQ - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_WIDTH-1:0]   r_ptr;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [ID_WIDTH-1:0]   r_id;
   logic [DATA_WIDTH-1:0] r_quot;
   logic [DATA_WIDTH-1:0] r_rem;
   logic                  r_dz;

   logic [NUM_REQ-1:0]    w_grant;
   logic [ID_WIDTH-1:0]   w_gidx;
   logic                  w_any;
   logic [DATA_WIDTH-1:0] w_sel_a;
   logic [DATA_WIDTH-1:0] w_sel_b;
   logic [DATA_WIDTH-1:0] w_div_q;
   logic [DATA_WIDTH-1:0] w_div_r;
   logic                  w_div_z;
   logic                  w_accept;
   logic                  w_capture;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_arbiter (
      .i_req       (req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx),
      .o_any_req   (w_any)
   );

   assign w_sel_a = req_a[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_b = req_b[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];

   // Divider sees only the latched operands, so it is stable for the whole CALC window.
   assign w_div_z = (r_b == '0);
   assign w_div_q = w_div_z ? '1  : (r_a / r_b);
   assign w_div_r = w_div_z ? r_a : (r_a % r_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               req_ready = w_grant;
               w_accept  = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
               w_state_nxt = (w_sel_b == '0) ? RESP : CALC;
`else
               w_state_nxt = CALC;
`endif
            end
         end
         CALC: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_cnt  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_id   <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_id  <= w_gidx;
            r_cnt <= c_cnt_init;
            r_ptr <= (w_gidx == c_last_id) ? '0 : (w_gidx + ID_WIDTH'(1));
`ifdef DIV_ZERO_BYPASS_EN
            if (w_sel_b == '0) begin
               r_quot <= '1;
               r_rem  <= w_sel_a;
               r_dz   <= 1'b1;
            end
`endif
         end else if ((r_state == CALC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_quot <= w_div_q;
            r_rem  <= w_div_r;
            r_dz   <= w_div_z;
         end
      end
   end

   assign rsp_valid     = (r_state == RESP);
   assign busy          = (r_state != IDLE);
   assign rsp_id        = r_id;
   assign rsp_quotient  = r_quot;
   assign rsp_remainder = r_rem;
   assign rsp_div_by_0  = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_div_share_arbiter
// Brief    : Directed self-checking bench for div_share_arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_div_share_arbiter;
   import div_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 10;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_quotient;
   logic [DW-1:0]     rsp_remainder;
   logic              rsp_div_by_0;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   div_result_t rr_exp [NR];

   div_share_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_div_by_0  (rsp_div_by_0),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_a[i*DW +: DW] = DW'(a);
      req_b[i*DW +: DW] = DW'(b);
   endtask

   task automatic check_rsp(input string tag, input int id, input div_result_t e);
      check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".id"},    32'(rsp_id), 32'(id));
      check({tag, ".quot"},  32'(rsp_quotient), 32'(e.quotient));
      check({tag, ".rem"},   32'(rsp_remainder), 32'(e.remainder));
      check({tag, ".dz"},    32'(rsp_div_by_0), 32'(e.div_by_0));
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      rr_exp[0] = '{quotient: 10'd33, remainder: 10'd1,  div_by_0: 1'b0};
      rr_exp[1] = '{quotient: 10'd28, remainder: 10'd4,  div_by_0: 1'b0};
      rr_exp[2] = '{quotient: 10'd27, remainder: 10'd3,  div_by_0: 1'b0};
      rr_exp[3] = '{quotient: 10'd30, remainder: 10'd10, div_by_0: 1'b0};

      // Reset state
      tick(); tick();
      check("rst.valid", 32'(rsp_valid), 32'd0);
      check("rst.busy",  32'(busy), 32'd0);
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.id",    32'(rsp_id), 32'd0);
      check("rst.quot",  32'(rsp_quotient), 32'd0);
      check("rst.rem",   32'(rsp_remainder), 32'd0);
      check("rst.dz",    32'(rsp_div_by_0), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request from requester 2: 1000 / 7
      set_req(2, 1000, 7);
      req_valid = 4'b0100;
      #1;
      check("single.ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check("single.ready_off", 32'(req_ready), 32'd0);
      check("single.busy", 32'(busy), 32'd1);
      check("single.valid_c0", 32'(rsp_valid), 32'd0);
      tick();
      check("single.valid_c1", 32'(rsp_valid), 32'd0);
      tick();
      check_rsp("single", 2, '{quotient: 10'd142, remainder: 10'd6, div_by_0: 1'b0});
      rsp_ready = 1'b1;
      tick();
      check("single.done_valid", 32'(rsp_valid), 32'd0);
      check("single.done_busy", 32'(busy), 32'd0);
      rsp_ready = 1'b0;

      // Boundary 1023 / 1 from requester 3 (pointer now 3)
      set_req(3, 1023, 1);
      req_valid = 4'b1000;
      #1;
      check("max.ready", 32'(req_ready), 32'b1000);
      tick();
      req_valid = '0;
      tick(); tick();
      check_rsp("max", 3, '{quotient: 10'd1023, remainder: 10'd0, div_by_0: 1'b0});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Boundary 5 / 9 from requester 1 (pointer wrapped to 0)
      set_req(1, 5, 9);
      req_valid = 4'b0010;
      #1;
      check("small.ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      tick(); tick();
      check_rsp("small", 1, '{quotient: 10'd0, remainder: 10'd5, div_by_0: 1'b0});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Divide by zero from requester 0 (pointer at 2, search wraps)
      set_req(0, 513, 0);
      req_valid = 4'b0001;
      #1;
      check("dz.ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
`ifdef DIV_ZERO_BYPASS_EN
      check_rsp("dz", 0, '{quotient: 10'd1023, remainder: 10'd513, div_by_0: 1'b1});
`else
      check("dz.valid_c0", 32'(rsp_valid), 32'd0);
      tick();
      check("dz.valid_c1", 32'(rsp_valid), 32'd0);
      tick();
      check_rsp("dz", 0, '{quotient: 10'd1023, remainder: 10'd513, div_by_0: 1'b1});
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset while in CALC (requester 1 granted, pointer at 1)
      set_req(1, 100, 3);
      req_valid = 4'b0010;
      #1;
      check("mid.ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      check("mid.busy_calc", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid.busy_async", 32'(busy), 32'd0);
      check("mid.valid_async", 32'(rsp_valid), 32'd0);
      tick();
      check("mid.quot_cleared", 32'(rsp_quotient), 32'd0);
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("mid.no_stale_valid", 32'(rsp_valid), 32'd0);
      check("mid.no_stale_busy", 32'(busy), 32'd0);

      // All four requesters held valid, consumer always ready
      set_req(0, 100, 3);
      set_req(1, 200, 7);
      set_req(2, 300, 11);
      set_req(3, 400, 13);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rr%0d.ready", k), 32'(req_ready), 32'd1 << (k % NR));
         tick();
         check($sformatf("rr%0d.ready_calc", k), 32'(req_ready), 32'd0);
         tick(); tick();
         check_rsp($sformatf("rr%0d", k), k % NR, rr_exp[k % NR]);
         tick();
      end

      // Backpressure: pointer at 1, all still valid
      rsp_ready = 1'b0;
      check("bp.ready", 32'(req_ready), 32'b0010);
      tick();
      tick(); tick();
      check_rsp("bp.first", 1, rr_exp[1]);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_rsp($sformatf("bp.hold%0d", k), 1, rr_exp[1]);
         check($sformatf("bp.busy%0d", k), 32'(busy), 32'd1);
         check($sformatf("bp.ready%0d", k), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      check("bp.release_valid", 32'(rsp_valid), 32'd0);
      check("bp.next_grant", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check("bp.next_busy", 32'(busy), 32'd1);
      tick(); tick();
      check_rsp("bp.next", 2, rr_exp[2]);
      tick();
      check("bp.idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
